// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the shift_arbiter block.
//   WIDTH_DEFAULT : default word length serialised per transfer
//   state_t       : controller states (IDLE -> SHIFT -> DONE -> IDLE)
// ---------------------------------------------------------------------------
package shift_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/piso_core.sv
// ---------------------------------------------------------------------------
// piso_core
// Parallel-in / serial-out shift register, shifting right with zero fill.
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous, active-low reset (clears the register)
//   load     : capture din into the register
//   shift_en : shift the register right by one bit
//   din      : parallel word to load
//   bit0     : current bit 0 of the register (next serial bit, LSB first)
// ---------------------------------------------------------------------------
module piso_core
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             bit0
);

  logic [WIDTH-1:0] sreg;

  // Load has priority; the controller never asserts both in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift_en) begin
      sreg <= {1'b0, sreg[WIDTH-1:1]};
    end
  end

  assign bit0 = sreg[0];

endmodule

// File: rtl/shift_arbiter.sv
// ---------------------------------------------------------------------------
// shift_arbiter
// Two-requester round-robin arbiter that serialises the winner's word,
// LSB first, over WIDTH consecutive valid cycles, then pulses done.
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous, active-low reset
//   req_a/b    : level requests, held until the matching grant
//   data_a/b   : parallel words, captured on the grant edge
//   gnt_a/b    : one-cycle grant pulses
//   serialout  : serial data bit (0 outside shift output cycles)
//   sout_valid : serialout carries a data bit this cycle
//   owner      : 0 = current/last transfer is A's, 1 = B's
//   done       : one-cycle pulse after the last bit
//   busy       : high whenever the controller is not in IDLE
// All outputs are registered.
// ---------------------------------------------------------------------------
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             serialout,
  output logic             sout_valid,
  output logic             owner,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  state_t          state;
  state_t          next_state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_d;
  logic            pref_b;
  logic            pref_b_d;

  logic            gnt_a_d;
  logic            gnt_b_d;
  logic            serial_d;
  logic            valid_d;
  logic            owner_d;
  logic            done_d;
  logic            busy_d;

  logic            grant_b;
  logic            load;
  logic            shift_en;
  logic [WIDTH-1:0] load_data;
  logic            piso_bit;

  piso_core #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift_en (shift_en),
    .din      (load_data),
    .bit0     (piso_bit)
  );

  // State and every output are registered here; all decisions live in the
  // combinational block below.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      pref_b     <= 1'b0;
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      serialout  <= 1'b0;
      sout_valid <= 1'b0;
      owner      <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= cnt_d;
      pref_b     <= pref_b_d;
      gnt_a      <= gnt_a_d;
      gnt_b      <= gnt_b_d;
      serialout  <= serial_d;
      sout_valid <= valid_d;
      owner      <= owner_d;
      done       <= done_d;
      busy       <= busy_d;
    end
  end

  // Next-state and next-output logic. Pulses (gnt, done) and the serial
  // outputs default to 0 so they only rise in the state that owns them.
  // pref_b remembers who should win the next tie: it points away from the
  // requester granted last, and resets to favour A.
  always_comb begin
    next_state = state;
    cnt_d      = cnt;
    pref_b_d   = pref_b;
    gnt_a_d    = 1'b0;
    gnt_b_d    = 1'b0;
    serial_d   = 1'b0;
    valid_d    = 1'b0;
    owner_d    = owner;
    done_d     = 1'b0;
    grant_b    = 1'b0;
    load       = 1'b0;
    shift_en   = 1'b0;
    load_data  = data_a;

    case (state)
      IDLE: begin
        if (req_a || req_b) begin
          grant_b    = req_b && (!req_a || pref_b);
          load       = 1'b1;
          load_data  = grant_b ? data_b : data_a;
          gnt_a_d    = !grant_b;
          gnt_b_d    = grant_b;
          owner_d    = grant_b;
          pref_b_d   = !grant_b;
          cnt_d      = '0;
          next_state = SHIFT;
        end
      end

      SHIFT: begin
        serial_d = piso_bit;
        valid_d  = 1'b1;
        shift_en = 1'b1;
        cnt_d    = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          next_state = DONE;
        end
      end

      DONE: begin
        done_d     = 1'b1;
        next_state = IDLE;
      end

      default: begin
        next_state = IDLE;
      end
    endcase

    busy_d = (next_state != IDLE);
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shift_arbiter
// Directed self-checking bench for shift_arbiter (WIDTH = 4).
// ---------------------------------------------------------------------------
module tb_shift_arbiter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_a;
  logic [W-1:0] data_a;
  logic         req_b;
  logic [W-1:0] data_b;
  logic         gnt_a;
  logic         gnt_b;
  logic         serialout;
  logic         sout_valid;
  logic         owner;
  logic         done;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int waited;

  shift_arbiter #(
    .WIDTH (W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_a      (req_a),
    .data_a     (data_a),
    .req_b      (req_b),
    .data_b     (data_b),
    .gnt_a      (gnt_a),
    .gnt_b      (gnt_b),
    .serialout  (serialout),
    .sout_valid (sout_valid),
    .owner      (owner),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic ra, input logic rb,
                               input logic [W-1:0] da, input logic [W-1:0] db);
    req_a  = ra;
    req_b  = rb;
    data_a = da;
    data_b = db;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " gnt_a"},      16'(gnt_a),      16'd0);
    checkOutput({tag, " gnt_b"},      16'(gnt_b),      16'd0);
    checkOutput({tag, " serialout"},  16'(serialout),  16'd0);
    checkOutput({tag, " sout_valid"}, 16'(sout_valid), 16'd0);
    checkOutput({tag, " owner"},      16'(owner),      16'd0);
    checkOutput({tag, " done"},       16'(done),       16'd0);
    checkOutput({tag, " busy"},       16'(busy),       16'd0);
  endtask

  // Called at a falling edge; advances until a grant is visible (bounded).
  task automatic waitGrant(input string tag, input logic exp_b, output int n);
    n = 0;
    while (!(gnt_a || gnt_b) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, " grant seen"}, 16'(gnt_a | gnt_b), 16'd1);
    checkOutput({tag, " gnt_b"},      16'(gnt_b),         16'(exp_b));
    checkOutput({tag, " gnt_a"},      16'(gnt_a),         16'(!exp_b));
    checkOutput({tag, " owner"},      16'(owner),         16'(exp_b));
    checkOutput({tag, " valid@gnt"},  16'(sout_valid),    16'd0);
    checkOutput({tag, " busy@gnt"},   16'(busy),          16'd1);
  endtask

  // Checks the W serial bits and the done cycle that follows a grant.
  // act: 1 = raise req_b during bit 2, 2 = change data_a after the grant,
  //      3 = one-cycle req_a pulse while busy.
  task automatic checkBits(input string tag, input logic [W-1:0] exp,
                           input logic exp_owner, input int act);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s valid[%0d]", tag, i), 16'(sout_valid), 16'd1);
      checkOutput($sformatf("%s bit[%0d]", tag, i),   16'(serialout),  16'(exp[i]));
      checkOutput($sformatf("%s nognt[%0d]", tag, i), 16'(gnt_a | gnt_b), 16'd0);
      checkOutput($sformatf("%s owner[%0d]", tag, i), 16'(owner),      16'(exp_owner));
      checkOutput($sformatf("%s nodone[%0d]", tag, i), 16'(done),      16'd0);
      if (act == 1 && i == 1) req_b = 1'b1;
      if (act == 2 && i == 0) data_a = 4'hA;
      if (act == 3 && i == 0) req_a = 1'b1;
      if (act == 3 && i == 1) req_a = 1'b0;
    end
    @(negedge clk);
    checkOutput({tag, " done"},         16'(done),       16'd1);
    checkOutput({tag, " valid@done"},   16'(sout_valid), 16'd0);
    checkOutput({tag, " serial@done"},  16'(serialout),  16'd0);
    checkOutput({tag, " busy@done"},    16'(busy),       16'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0);
    #12;
    checkResetOutputs("reset");
    @(negedge clk);
    reset = 1'b1;

    // Single A transfer: 4'b1011 -> 1,1,0,1
    applyStimulus(1'b1, 1'b0, 4'b1011, 4'h0);
    waitGrant("singleA", 1'b0, waited);
    req_a = 1'b0;
    checkBits("singleA", 4'b1011, 1'b0, 0);

    // Fresh reset so the tie goes to A
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Tie with both held: A, B, A, grants 6 cycles apart
    applyStimulus(1'b1, 1'b1, 4'h3, 4'hC);
    waitGrant("tieA", 1'b0, waited);
    checkBits("tieA", 4'h3, 1'b0, 0);
    waitGrant("tieB", 1'b1, waited);
    checkOutput("tieB spacing", 16'(waited), 16'd1);
    checkBits("tieB", 4'hC, 1'b1, 0);
    waitGrant("tieA2", 1'b0, waited);
    checkOutput("tieA2 spacing", 16'(waited), 16'd1);
    applyStimulus(1'b0, 1'b0, 4'h3, 4'hC);
    checkBits("tieA2", 4'h3, 1'b0, 0);

    // Pending B raised during A's second bit
    applyStimulus(1'b1, 1'b0, 4'h6, 4'h9);
    waitGrant("pendA", 1'b0, waited);
    req_a = 1'b0;
    checkBits("pendA", 4'h6, 1'b0, 1);
    waitGrant("pendB", 1'b1, waited);
    checkOutput("pendB spacing", 16'(waited), 16'd1);
    req_b = 1'b0;
    checkBits("pendB", 4'h9, 1'b1, 0);

    // Data hold: word captured on the grant edge
    applyStimulus(1'b1, 1'b0, 4'h5, 4'h0);
    waitGrant("hold", 1'b0, waited);
    req_a = 1'b0;
    checkBits("hold", 4'h5, 1'b0, 2);

    // Dropped A request while B is busy
    applyStimulus(1'b0, 1'b1, 4'h5, 4'h2);
    waitGrant("drop", 1'b1, waited);
    req_b = 1'b0;
    checkBits("drop", 4'h2, 1'b1, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("drop nognt[%0d]", i), 16'(gnt_a | gnt_b), 16'd0);
      checkOutput($sformatf("drop idle[%0d]", i),  16'(busy),          16'd0);
    end

    // Mid-transfer reset after bit 2 of 4'hF
    applyStimulus(1'b1, 1'b0, 4'hF, 4'h4);
    waitGrant("midrst", 1'b0, waited);
    req_a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput($sformatf("midrst bit[%0d]", i), 16'(serialout), 16'd1);
    end
    reset = 1'b0;
    #1;
    checkResetOutputs("midrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("midrst nodone[%0d]", i), 16'(done), 16'd0);
    end
    applyStimulus(1'b0, 1'b1, 4'hF, 4'h4);
    reset = 1'b1;
    waitGrant("afterrst", 1'b1, waited);
    checkOutput("afterrst latency", 16'(waited), 16'd1);
    req_b = 1'b0;
    checkBits("afterrst", 4'h4, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the word length serialised per transfer (legal range 2..16).
REQ-002 SHALL have port clk  input  1  the single rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_a  input  1  requester A transfer request, level, held until gnt_a.
REQ-005 SHALL have port data_a  input  WIDTH  requester A parallel word, sampled on the grant edge.
REQ-006 SHALL have port req_b  input  1  requester B transfer request, same rules as req_a.
REQ-007 SHALL have port data_b  input  WIDTH  requester B parallel word.
REQ-008 SHALL have port gnt_a  output  1  one-cycle pulse, A's word has been captured.
REQ-009 SHALL have port gnt_b  output  1  one-cycle pulse, B's word has been captured.
REQ-010 SHALL have port serialout  output  1  serial data bit, LSB first.
REQ-011 SHALL have port sout_valid  output  1  serialout carries a data bit this cycle.
REQ-012 SHALL have port owner  output  1  0 = current/last transfer is A's, 1 = B's.
REQ-013 SHALL have port done  output  1  one-cycle pulse, transfer complete.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE; all outputs registered.
REQ-016 In IDLE, at an edge with req_a or req_b high, SHALL: load winner's data into the shift register, pulse gnt of the winner for the next cycle, set owner, clear bit counter, go to SHIFT.
REQ-017 Arbitration SHALL be round-robin: single request wins; if both requests are high, the requester not granted last wins; after reset A wins a tie.
REQ-018 In SHIFT, each edge SHALL drive serialout <= shift register bit 0, sout_valid <= 1, shift the register right by one (zero fill), and increment the counter.
REQ-019 On the edge emitting bit WIDTH-1, SHALL go to DONE; exactly WIDTH consecutive valid bits per transfer.
REQ-020 In DONE, next edge SHALL drive done <= 1, sout_valid <= 0, serialout <= 0, go to IDLE.
REQ-021 Timing: request seen at edge k -> gnt high in cycle after k; bits valid after edges k+1..k+WIDTH; done high after edge k+WIDTH+1; next grant earliest at edge k+WIDTH+2.
REQ-022 Requests arriving in SHIFT/DONE SHALL stay pending and be arbitrated on return to IDLE; no grant while busy.
REQ-023 A request dropped before its grant SHALL cause no transfer; a request still high after done SHALL start a new transfer.
REQ-024 data_x changes after the grant edge SHALL not affect the transfer in progress.
REQ-025 sout_valid and serialout SHALL be 0 in every cycle outside SHIFT output cycles.

Reset
REQ-026 reset low SHALL immediately force state IDLE, shift register 0, counter 0, round-robin pointer to "A preferred", and gnt_a, gnt_b, serialout, sout_valid, owner, done, busy all 0.
REQ-027 Reset asserted mid-transfer SHALL abort it with no done pulse; the first edge after release SHALL behave as IDLE.

Structure
REQ-028 A shared package shift_pkg SHALL hold the FSM state enum and the default WIDTH constant.
REQ-029 Serialisation SHALL be a sub-module piso_core (parallel load, shift-right enable, bit-0 output); shift_arbiter holds the FSM, counter and arbiter.

Verification
REQ-030 Single A: WIDTH=4, data_a=4'b1011, req_a pulse until gnt_a -> serialout 1,1,0,1 with sout_valid over 4 cycles, owner=0, then one done pulse.
REQ-031 Tie after reset: req_a=req_b=1 held, data_a=4'h3, data_b=4'hC -> A (1,1,0,0), then B (0,0,1,1), then A again; 6 cycles from one grant to the next.
REQ-032 Pending request: req_b rises during A's second bit -> gnt_b exactly one cycle after done, no overlap with A's bits.
REQ-033 Mid-transfer reset: reset low after bit 2 of 4'hF -> all outputs 0 at once, no done; after release with req_a=0, req_b=1 -> B granted first.
REQ-034 Data hold: change data_a from 4'h5 to 4'hA on the cycle after gnt_a -> bits still 1,0,1,0 (from 4'h5).
REQ-035 Dropped request: req_a high one cycle while busy, low before IDLE -> no gnt_a, busy falls after done.
